// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for unified_mem_arbiter.
//   arb_state_e   : arbiter FSM states (idle, issue, wait, done)
//   owner_e       : which port owns the in-flight transaction
//   DmTypeWord    : DMType code for a full 32-bit word access
//   DefTimeout    : default WAIT-state timeout in cycles
//   DefMaxDStreak : default max consecutive data grants while fetch waits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  typedef enum logic {
    OwnIf,
    OwnD
  } owner_e;

  localparam logic [2:0] DmTypeWord = 3'b010;

  localparam int unsigned DefTimeout    = 64;
  localparam int unsigned DefMaxDStreak = 4;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// mem_arb_perf_cnt: three 32-bit saturating event counters for the arbiter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_inc_conflict    : count one IDLE cycle with both requests present
//   i_inc_if_wait     : count one cycle of fetch stalled
//   i_inc_timeout     : count one timed-out transaction
//   o_perf_*          : counter values, stick at all-ones
module mem_arb_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc_conflict,
  input  logic        i_inc_if_wait,
  input  logic        i_inc_timeout,
  output logic [31:0] o_perf_conflict,
  output logic [31:0] o_perf_if_wait,
  output logic [31:0] o_perf_timeout
);

  logic [31:0] r_conflict;
  logic [31:0] r_if_wait;
  logic [31:0] r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= '0;
      r_if_wait  <= '0;
      r_timeout  <= '0;
    end else begin
      if (i_inc_conflict && (r_conflict != '1)) r_conflict <= r_conflict + 32'd1;
      if (i_inc_if_wait && (r_if_wait != '1))   r_if_wait  <= r_if_wait + 32'd1;
      if (i_inc_timeout && (r_timeout != '1))   r_timeout  <= r_timeout + 32'd1;
    end
  end

  assign o_perf_conflict = r_conflict;
  assign o_perf_if_wait  = r_if_wait;
  assign o_perf_timeout  = r_timeout;

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the fetch port
// and the MEM-stage data port, one outstanding transaction at a time.
// Optional feature macro: UNIFIED_MEM_ARBITER_PERF_EN adds o_perf_* counters.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   i_if_req/i_if_addr            : fetch request, held until o_if_ready
//   o_if_ready/o_if_rdata         : fetch completion pulse and instruction
//   i_d_req/we/addr/wdata/dmtype  : data request, held until o_d_ready
//   o_d_ready/o_d_rdata           : data completion pulse and load data
//   o_m_req/we/dmtype/addr/wdata  : registered memory command
//   i_m_gnt                       : memory accepted the command
//   i_m_rvalid/i_m_rdata          : memory completion and read data
//   o_err                         : pulse alongside ready of a timed-out access
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = DefMaxDStreak,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_dmtype,
  output logic        o_d_ready,
  output logic [31:0] o_d_rdata,
  output logic        o_m_req,
  output logic        o_m_we,
  output logic [2:0]  o_m_dmtype,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_gnt,
  input  logic        i_m_rvalid,
  input  logic [31:0] i_m_rdata,
  output logic        o_err
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] o_perf_conflict,
  output logic [31:0] o_perf_if_wait,
  output logic [31:0] o_perf_timeout
`endif
);

  localparam logic [3:0] MaxDStreak  = 4'(MAX_DSTREAK);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  arb_state_e  r_state;
  arb_state_e  w_next_state;
  owner_e      r_owner;
  logic [3:0]  r_dstreak;
  logic [7:0]  r_wait_cnt;
  logic        r_err;
  logic        r_m_req;
  logic        r_m_we;
  logic [2:0]  r_m_dmtype;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic w_any_req;
  logic w_grant_if;
  logic w_timeout;

  assign w_any_req = i_if_req | i_d_req;
  // Data is older in program order, so it wins unless fetch has been starved.
  assign w_grant_if = i_if_req & (~i_d_req | (r_dstreak == MaxDStreak));
  assign w_timeout  = (r_wait_cnt == TimeoutLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_next_state = StIssue;
      StIssue: if (i_m_gnt) w_next_state = StWait;
      StWait:  if (i_m_rvalid || w_timeout) w_next_state = StDone;
      StDone:  w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OwnIf;
      r_dstreak  <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_dmtype <= '0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_m_req <= 1'b1;
            r_err   <= 1'b0;
            if (w_grant_if) begin
              r_owner    <= OwnIf;
              r_m_we     <= 1'b0;
              r_m_dmtype <= DmTypeWord;
              r_m_addr   <= i_if_addr;
              r_m_wdata  <= '0;
            end else begin
              r_owner    <= OwnD;
              r_m_we     <= i_d_we;
              r_m_dmtype <= i_d_dmtype;
              r_m_addr   <= i_d_addr;
              r_m_wdata  <= i_d_wdata;
            end
            // Streak only grows while a fetch is actually being held off.
            if (w_grant_if || !i_if_req) r_dstreak <= '0;
            else if (r_dstreak != 4'hF)  r_dstreak <= r_dstreak + 4'd1;
          end
        end
        StIssue: begin
          if (i_m_gnt) begin
            r_m_req    <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        StWait: begin
          if (i_m_rvalid) begin
            if (r_owner == OwnIf) r_if_rdata <= i_m_rdata;
            else                  r_d_rdata  <= i_m_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner == OwnIf) r_if_rdata <= '0;
            else                  r_d_rdata  <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_if_ready = (r_state == StDone) && (r_owner == OwnIf);
  assign o_d_ready  = (r_state == StDone) && (r_owner == OwnD);
  assign o_err      = (r_state == StDone) && r_err;
  assign o_if_rdata = r_if_rdata;
  assign o_d_rdata  = r_d_rdata;
  assign o_m_req    = r_m_req;
  assign o_m_we     = r_m_we;
  assign o_m_dmtype = r_m_dmtype;
  assign o_m_addr   = r_m_addr;
  assign o_m_wdata  = r_m_wdata;

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  logic w_inc_conflict;
  logic w_inc_if_wait;

  assign w_inc_conflict = (r_state == StIdle) & i_if_req & i_d_req;
  assign w_inc_if_wait  = i_if_req & ~o_if_ready;

  mem_arb_perf_cnt u_perf_cnt (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_inc_conflict  (w_inc_conflict),
    .i_inc_if_wait   (w_inc_if_wait),
    .i_inc_timeout   (o_err),
    .o_perf_conflict (o_perf_conflict),
    .o_perf_if_wait  (o_perf_if_wait),
    .o_perf_timeout  (o_perf_timeout)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench for unified_mem_arbiter.
// Requesters and the memory model drive inputs 1 time unit after the rising
// edge; a monitor on the falling edge pops expected completions and compares.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_dmtype = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [2:0]  m_dmtype;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        err;
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_if_wait;
  logic [31:0] perf_timeout;
`endif

  unified_mem_arbiter #(
    .MAX_DSTREAK (4),
    .TIMEOUT     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_ready (if_ready),
    .o_if_rdata (if_rdata),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .i_d_dmtype (d_dmtype),
    .o_d_ready  (d_ready),
    .o_d_rdata  (d_rdata),
    .o_m_req    (m_req),
    .o_m_we     (m_we),
    .o_m_dmtype (m_dmtype),
    .o_m_addr   (m_addr),
    .o_m_wdata  (m_wdata),
    .i_m_gnt    (m_gnt),
    .i_m_rvalid (m_rvalid),
    .i_m_rdata  (m_rdata),
    .o_err      (err)
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    ,
    .o_perf_conflict (perf_conflict),
    .o_perf_if_wait  (perf_if_wait),
    .o_perf_timeout  (perf_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    bit          err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t cmd_q[$];

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_ready = 0;
  int unsigned cyc = 0;
  int unsigned last_if_cyc = 0;
  int unsigned last_d_cyc = 0;
  int unsigned gnt_cyc = 0;

  // Memory model knobs.
  int          gnt_delay = 0;
  bit          rv_never = 1'b0;
  bit          pend = 1'b0;
  bit          stray_req = 1'b0;
  int          gcnt = 0;
  logic [31:0] pend_addr = '0;
  logic        pend_we = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0010_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_if, input logic [31:0] data, input bit e);
    exp_t x;
    x.is_if = is_if;
    x.data  = data;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_ready(input bit is_if);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_if ? if_ready : d_ready) && n < 200);
    if (n >= 200) chk(is_if ? "if_ready_wait" : "d_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    wait_ready(1'b1);
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input bit drop);
    d_we     = we;
    d_addr   = a;
    d_wdata  = wd;
    d_dmtype = DmTypeWord;
    d_req    = 1'b1;
    wait_ready(1'b0);
    if (drop) d_req = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: grants after gnt_delay ISSUE cycles, completes one cycle later.
  initial forever begin
    cmd_t c;
    @(posedge clk);
    #1;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    if (pend && !rv_never) begin
      m_rvalid = 1'b1;
      m_rdata  = pend_we ? 32'd0 : mem_rd(pend_addr);
      pend     = 1'b0;
    end else if (stray_req) begin
      m_rvalid  = 1'b1;
      m_rdata   = 32'hDEAD_BEEF;
      stray_req = 1'b0;
    end
    if (m_req) begin
      if (gcnt >= gnt_delay) begin
        m_gnt     = 1'b1;
        gcnt      = 0;
        pend      = 1'b1;
        pend_addr = m_addr;
        pend_we   = m_we;
        gnt_cyc   = cyc;
        c.addr    = m_addr;
        c.we      = m_we;
        c.wdata   = m_wdata;
        c.dmtype  = m_dmtype;
        cmd_q.push_back(c);
      end else begin
        gcnt++;
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (if_ready || d_ready)) begin
      n_ready++;
      if (if_ready) last_if_cyc = cyc;
      if (d_ready)  last_d_cyc  = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {30'd0, if_ready, d_ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ready_port", {30'd0, if_ready, d_ready}, e.is_if ? 32'd2 : 32'd1);
        chk("rdata", e.is_if ? if_rdata : d_rdata, e.data);
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned start;
    int          r0;
    int          n;
    logic [31:0] a0;
    logic [31:0] exp_addr [6];

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch.
    cmd_q.delete();
    start = cyc;
    push_exp(1'b1, 32'h0010_0093, 1'b0);
    fetch_txn(32'h40);
    chk("fetch_latency", last_if_cyc - start, 32'd3);
    chk("fetch_cmds", cmd_q.size(), 32'd1);
    if (cmd_q.size() > 0) begin
      chk("fetch_m_we", 32'(cmd_q[0].we), 32'd0);
      chk("fetch_m_dmtype", 32'(cmd_q[0].dmtype), 32'(DmTypeWord));
      chk("fetch_m_addr", cmd_q[0].addr, 32'h40);
    end

    // Simultaneous requests: data first, fetch 4 cycles later.
    cmd_q.delete();
    push_exp(1'b0, 32'd0, 1'b0);
    push_exp(1'b1, mem_rd(32'h80), 1'b0);
    fork
      data_txn(1'b1, 32'h100, 32'hCAFE_F00D, 1'b1);
      fetch_txn(32'h80);
    join
    chk("simul_ready_gap", last_if_cyc - last_d_cyc, 32'd4);
    chk("simul_cmds", cmd_q.size(), 32'd2);
    if (cmd_q.size() > 1) begin
      chk("simul_d_we", 32'(cmd_q[0].we), 32'd1);
      chk("simul_d_wdata", cmd_q[0].wdata, 32'hCAFE_F00D);
      chk("simul_d_addr", cmd_q[0].addr, 32'h100);
      chk("simul_if_addr", cmd_q[1].addr, 32'h80);
    end

    // Starvation guard: D,D,D,D,IF,D.
    cmd_q.delete();
    exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h84, 32'h210};
    for (int i = 0; i < 6; i++) begin
      push_exp(exp_addr[i] == 32'h84, mem_rd(exp_addr[i]), 1'b0);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          data_txn(1'b0, 32'h200 + 32'(4 * i), 32'd0, i == 4);
        end
      end
      fetch_txn(32'h84);
    join
    chk("starve_cmds", cmd_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < cmd_q.size()) chk($sformatf("starve_order%0d", i), cmd_q[i].addr, exp_addr[i]);
    end

    // Slow grant: command must stay put through every ISSUE cycle.
    gnt_delay = 2;
    push_exp(1'b1, mem_rd(32'h88), 1'b0);
    fork
      fetch_txn(32'h88);
      begin
        n = 0;
        while (!m_req && n < 20) begin
          @(negedge clk);
          n++;
        end
        n = 0;
        a0 = 32'h88;
        while (m_req && n < 10) begin
          chk("slow_m_addr", m_addr, a0);
          n++;
          @(negedge clk);
        end
        chk("slow_issue_cycles", 32'(n), 32'd3);
      end
    join
    gnt_delay = 0;

    // Timeout: no completion ever arrives.
    rv_never = 1'b1;
    push_exp(1'b0, 32'd0, 1'b1);
    data_txn(1'b0, 32'h300, 32'd0, 1'b1);
    chk("timeout_latency", last_d_cyc - gnt_cyc, 32'd9);
    pend      = 1'b0;
    rv_never  = 1'b0;
    r0        = n_ready;
    stray_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stray_after_timeout", 32'(n_ready), 32'(r0));
    chk("d_rdata_hold", d_rdata, 32'd0);

    // Reset in the middle of WAIT.
    rv_never = 1'b1;
    if_addr  = 32'h44;
    if_req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_m_addr", m_addr, 32'h44);
    rst_n  = 1'b0;
    if_req = 1'b0;
    #1;
    chk("wrst_m_req", 32'(m_req), 32'd0);
    chk("wrst_m_addr", m_addr, 32'd0);
    chk("wrst_m_ctl", {28'd0, m_we, m_dmtype}, 32'd0);
    chk("wrst_m_wdata", m_wdata, 32'd0);
    chk("wrst_ready_err", {29'd0, if_ready, d_ready, err}, 32'd0);
    chk("wrst_if_rdata", if_rdata, 32'd0);
    chk("wrst_d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    r0       = n_ready;
    rv_never = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stray_after_reset", 32'(n_ready), 32'(r0));

    // Fresh fetch after reset completes normally.
    start = cyc;
    push_exp(1'b1, 32'h0010_0093, 1'b0);
    fetch_txn(32'h40);
    chk("post_rst_latency", last_if_cyc - start, 32'd3);

    repeat (3) @(posedge clk);
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

- Shares one single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Arbitrates between the two ports, drives the memory handshake, and returns a one-cycle `ready` pulse to the winning port.
- Supports one outstanding transaction at a time.
- Sits between the pipelined CPU core and the memory model; the core stalls on a port until that port's `ready` arrives.

## Interface
- `MAX_DSTREAK`, 4: maximum consecutive data grants while fetch is pending (1..15).
- `TIMEOUT`, 64: WAIT-state cycles before the transaction is aborted (2..255).
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_ready`.
- `if_addr` in 32: fetch address (PC).
- `if_ready` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: fetched instruction.
- `d_req` in 1: data request; held with `d_*` until `d_ready`.
- `d_we` in 1: 1 = store.
- `d_addr` in 32: data address (ALU result).
- `d_wdata` in 32: store data.
- `d_dmtype` in 3: access width/sign code (shared DMType encoding).
- `d_ready` out 1: one-cycle pulse; `d_rdata` valid (loads).
- `d_rdata` out 32: load data.
- `m_req`, `m_we`, `m_dmtype`, `m_addr`, `m_wdata`: outputs of width 1/1/3/32/32; the registered memory command.
- `m_gnt` in 1: memory accepted the command.
- `m_rvalid` in 1: memory completion; `m_rdata` valid; also acknowledges stores.
- `m_rdata` in 32: memory read data.
- `err` out 1: one-cycle pulse concurrent with the `ready` of a timed-out transaction.

## Operation
- FSM states:
  - IDLE:
    - Arbitrate.
    - If any request is present, latch the winner's command into the `m_*` registers, record the owner, and go to ISSUE.
    - Fetch commands drive `m_we`=0 and `m_dmtype`=word.
  - ISSUE:
    - `m_req`=1.
    - When `m_gnt` is sampled high, go to WAIT and set `m_req`=0 next cycle.
  - WAIT:
    - On `m_rvalid`, capture `m_rdata` and go to DONE.
    - If the wait counter reaches `TIMEOUT`-1 without `m_rvalid`, go to DONE with the error flag set and captured data = 0.
  - DONE:
    - The owner's `ready`=1 for exactly this cycle; `err`=1 if timed out.
    - Go to IDLE.
- Arbitration in IDLE:
  - `d_req` wins by default, because the data access is older in program order.
  - Exception: `if_req` wins when `dstreak` == `MAX_DSTREAK`.
- `dstreak` (4-bit) update at each IDLE grant:
  - Data granted and `if_req`=1: `dstreak`+1, saturating.
  - Fetch granted or `if_req`=0: `dstreak`=0.
- `m_rvalid` outside WAIT is a stray response: ignore it, change no state, and produce no `ready`.
- `m_gnt` outside ISSUE is ignored.
- Requests are sampled only in IDLE; changes to a requester's inputs while it is not granted have no effect.
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE; all outputs 0; `dstreak`=0; wait counter 0.
  - Any in-flight memory transaction is abandoned, and its later `m_rvalid` is treated as stray.

## Timing
- Best case, with `m_gnt` in the first ISSUE cycle and `m_rvalid` in the first WAIT cycle:
  - Request seen at edge 0; ISSUE in cycle 1; WAIT in cycle 2; `ready` in cycle 3.
  - Back-to-back throughput is one transaction per 4 cycles, because DONE is followed by IDLE.
- DONE is followed by IDLE so the requester can drop or update its request on the `ready` edge. The next request is sampled in that IDLE cycle.
- `m_*` outputs are registered and stable from ISSUE entry through WAIT.
- `if_rdata` and `d_rdata` are registered; they hold their value until the next DONE of the same port.
- The wait counter resets on entry to WAIT; the timeout fires after `TIMEOUT` WAIT cycles.

## Configuration
- `UNIFIED_MEM_ARBITER_PERF_EN` defined: adds the following outputs, each 32-bit, reset to 0 and saturating at all-ones:
  - `perf_conflict`: +1 each IDLE cycle with both requests present.
  - `perf_if_wait`: +1 each cycle with `if_req`=1 and `if_ready`=0.
  - `perf_timeout`: +1 per `err` pulse.
- Undefined: these ports and the counters do not exist; arbitration behaviour is identical.

## Structure
- Package `mem_arb_pkg` holds:
  - The state enum (IDLE, ISSUE, WAIT, DONE).
  - The owner enum (OWN_IF, OWN_D).
  - The DMType word code.
  - The default `TIMEOUT` and `MAX_DSTREAK` constants.
- Sub-module `mem_arb_perf_cnt` holds the three saturating counters. It is instantiated only under `UNIFIED_MEM_ARBITER_PERF_EN`.

## Test plan
- Lone fetch:
  - Stimulus: `if_addr`=0x0000_0040, `m_gnt` immediate, `m_rvalid` with `m_rdata`=0x0010_0093 one cycle later.
  - Required: `if_ready` in cycle 3 with `if_rdata`=0x0010_0093; `m_we`=0.
- Simultaneous requests:
  - Stimulus: `d_req` store to 0x100 with 0xCAFE_F00D, plus `if_req`, in the same cycle.
  - Required: data served first (`m_we`=1, `m_wdata`=0xCAFE_F00D); fetch served next; `d_ready` precedes `if_ready` by 4 cycles.
- Starvation guard:
  - Stimulus: `MAX_DSTREAK`=4; `d_req` and `if_req` held continuously.
  - Required: grant order D,D,D,D,IF,D…
- Timeout:
  - Stimulus: `TIMEOUT`=8; `m_gnt` given, `m_rvalid` never asserted.
  - Required: after 8 WAIT cycles, DONE with `d_ready`=1, `err`=1, `d_rdata`=0; a later stray `m_rvalid` is ignored.
- Reset in WAIT:
  - Stimulus: `rst_n` pulsed low mid-WAIT.
  - Required: all outputs 0 immediately; a following `m_rvalid` produces no `ready`; a new fetch then completes normally.
- Slow grant:
  - Stimulus: `m_gnt` delayed 3 cycles.
  - Required: `m_req` and `m_addr` held stable for all 3 ISSUE cycles.
